// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and field indices for the conv layer scheduler
package conv_pkg;

    localparam int ROW_WIDTH = 10;

    // Field positions inside an rcc tuple
    localparam int RCC_ROW = 2;
    localparam int RCC_COL = 1;
    localparam int RCC_CH  = 0;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BUF,
        ISSUE,
        SWITCH,
        DONE
    } sched_state_e;

    typedef logic [2:0][ROW_WIDTH-1:0] rcc_t;

endpackage

// File: rtl/nested_counter3.sv
// rtl/nested_counter3.sv - row/col/channel wrap counter with per-level end flags
module nested_counter3 #(
    parameter int ROW_WIDTH = 10,
    parameter int OUT_H     = 28,
    parameter int OUT_W     = 28,
    parameter int C         = 256,
    parameter int BAND_ROWS = 7
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 advance,
    input  logic                 clear,
    output logic [ROW_WIDTH-1:0] row,
    output logic [ROW_WIDTH-1:0] col,
    output logic [ROW_WIDTH-1:0] ch,
    output logic                 last_ch,
    output logic                 last_col,
    output logic                 band_end,
    output logic                 last_all
);

    localparam logic [ROW_WIDTH-1:0] CH_MAX   = ROW_WIDTH'(C - 1);
    localparam logic [ROW_WIDTH-1:0] COL_MAX  = ROW_WIDTH'(OUT_W - 1);
    localparam logic [ROW_WIDTH-1:0] ROW_MAX  = ROW_WIDTH'(OUT_H - 1);
    localparam logic [ROW_WIDTH-1:0] BAND_MAX = ROW_WIDTH'(BAND_ROWS - 1);
    localparam logic [ROW_WIDTH-1:0] ONE      = ROW_WIDTH'(1);

    // Row position within the current band; avoids a modulo on the row count
    logic [ROW_WIDTH-1:0] band_row;
    logic                 last_row;

    // Flags are per level: the caller ANDs them to find row, band and layer ends
    assign last_ch  = (ch == CH_MAX);
    assign last_col = (col == COL_MAX);
    assign last_row = (row == ROW_MAX);
    assign band_end = (band_row == BAND_MAX) && !last_row;
    assign last_all = last_row;

    // Channel innermost, then column, then row; the band row tracks the row
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row      <= '0;
            col      <= '0;
            ch       <= '0;
            band_row <= '0;
        end else if (clear) begin
            row      <= '0;
            col      <= '0;
            ch       <= '0;
            band_row <= '0;
        end else if (advance) begin
            if (!last_ch) begin
                ch <= ch + ONE;
            end else begin
                ch <= '0;
                if (!last_col) begin
                    col <= col + ONE;
                end else begin
                    col <= '0;
                    if (last_row) begin
                        row      <= '0;
                        band_row <= '0;
                    end else begin
                        row      <= row + ONE;
                        band_row <= (band_row == BAND_MAX) ? '0 : band_row + ONE;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/pe_row_scheduler.sv
// rtl/pe_row_scheduler.sv - walks every output position and feeds rcc tuples to the PE side
module pe_row_scheduler #(
    parameter int ROW_WIDTH = 10,
    parameter int OUT_H     = 28,
    parameter int OUT_W     = 28,
    parameter int C         = 256,
    parameter int BAND_ROWS = 7
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start,
    input  logic                      buf_ready,
    output logic [2:0][ROW_WIDTH-1:0] rcc,
    output logic                      rcc_valid,
    input  logic                      rcc_ready,
    output logic                      ram_switch,
    output logic                      busy,
    output logic                      done
);

    import conv_pkg::*;

    if ((C > (1 << ROW_WIDTH)) || (OUT_W > (1 << ROW_WIDTH)) || (OUT_H > (1 << ROW_WIDTH))) begin : g_width_check
        $error("pe_row_scheduler: C, OUT_W and OUT_H must fit in ROW_WIDTH bits");
    end

    if ((BAND_ROWS < 1) || ((OUT_H % BAND_ROWS) != 0)) begin : g_band_check
        $error("pe_row_scheduler: OUT_H must be a multiple of BAND_ROWS");
    end

    sched_state_e         state;
    logic [ROW_WIDTH-1:0] row_cnt;
    logic [ROW_WIDTH-1:0] col_cnt;
    logic [ROW_WIDTH-1:0] ch_cnt;
    logic                 last_ch;
    logic                 last_col;
    logic                 band_end;
    logic                 last_all;
    logic                 hs;
    logic                 row_wrap;
    logic                 band_switch;
    logic                 layer_end;

    assign hs          = rcc_valid & rcc_ready;
    assign row_wrap    = last_ch & last_col;
    assign band_switch = row_wrap & band_end;
    assign layer_end   = row_wrap & last_all;

    // Counters are flops, so rcc is registered; it only moves on a handshake
    assign rcc[RCC_ROW] = row_cnt;
    assign rcc[RCC_COL] = col_cnt;
    assign rcc[RCC_CH]  = ch_cnt;

    nested_counter3 #(
        .ROW_WIDTH (ROW_WIDTH),
        .OUT_H     (OUT_H),
        .OUT_W     (OUT_W),
        .C         (C),
        .BAND_ROWS (BAND_ROWS)
    ) u_counter (
        .clk      (clk),
        .rstn     (rstn),
        .advance  (hs),
        .clear    (state == DONE),
        .row      (row_cnt),
        .col      (col_cnt),
        .ch       (ch_cnt),
        .last_ch  (last_ch),
        .last_col (last_col),
        .band_end (band_end),
        .last_all (last_all)
    );

    // Sequencer FSM with registered handshake, switch, busy and done outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            rcc_valid  <= 1'b0;
            ram_switch <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= WAIT_BUF;
                        busy  <= 1'b1;
                    end
                end
                WAIT_BUF: begin
                    if (buf_ready) begin
                        state     <= ISSUE;
                        rcc_valid <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (hs) begin
                        if (layer_end) begin
                            state     <= DONE;
                            rcc_valid <= 1'b0;
                            done      <= 1'b1;
                        end else if (band_switch) begin
                            state      <= SWITCH;
                            rcc_valid  <= 1'b0;
                            ram_switch <= 1'b1;
                        end
                    end
                end
                SWITCH: begin
                    // buf_ready still reflects the old band here, so it is not looked at
                    ram_switch <= 1'b0;
                    state      <= WAIT_BUF;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    rcc_valid  <= 1'b0;
                    ram_switch <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

endmodule
